pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 177 +++++++++++++++++
 tb/tb_pwm_capture.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM high-time / period capture with a valid/ready result handshake and a no-edge timeout.
// Optional macro PWM_CAPTURE_SYNC_EN selects a two-flop input synchronizer instead of one flop.
module pwm_capture #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MAX_PERIOD = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             overrun,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] One    = CNT_W'(1);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    logic s;
    logic p_q;

    // Input stage flops reset to 1 so a high input at reset release is not seen as a rise.
`ifdef PWM_CAPTURE_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], pwm_in};
        end
    end
    assign s = sync_q[1];
`else
    logic sync_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= 1'b1;
        end else begin
            sync_q <= pwm_in;
        end
    end
    assign s = sync_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            p_q <= 1'b1;
        end else begin
            p_q <= s;
        end
    end

    logic rise;
    logic fall;
    assign rise = s & ~p_q;
    assign fall = ~s & p_q;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] h_acc_q, h_acc_d;
    logic [CNT_W-1:0] p_acc_q, p_acc_d;
    logic             timeout_q, timeout_d;
    logic             complete;

    always_comb begin
        state_d   = state_q;
        h_acc_d   = h_acc_q;
        p_acc_d   = p_acc_q;
        timeout_d = 1'b0;
        complete  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StHigh;
                    h_acc_d = One;
                    p_acc_d = One;
                end
            end
            StHigh: begin
                if (p_acc_q >= MaxCnt) begin
                    state_d   = StIdle;
                    h_acc_d   = '0;
                    p_acc_d   = '0;
                    timeout_d = 1'b1;
                end else if (fall) begin
                    state_d = StLow;
                    p_acc_d = p_acc_q + One;
                end else if (s) begin
                    h_acc_d = h_acc_q + One;
                    p_acc_d = p_acc_q + One;
                end
            end
            StLow: begin
                if (p_acc_q >= MaxCnt) begin
                    state_d   = StIdle;
                    h_acc_d   = '0;
                    p_acc_d   = '0;
                    timeout_d = 1'b1;
                end else if (rise) begin
                    complete = 1'b1;
                    state_d  = StHigh;
                    h_acc_d  = One;
                    p_acc_d  = One;
                end else begin
                    p_acc_d = p_acc_q + One;
                end
            end
            default: begin
                state_d = StIdle;
                h_acc_d = '0;
                p_acc_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            h_acc_q   <= '0;
            p_acc_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_acc_q   <= h_acc_d;
            p_acc_q   <= p_acc_d;
            timeout_q <= timeout_d;
        end
    end

    logic             valid_q, valid_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             overrun_q, overrun_d;

    // A completion may load whenever the slot is empty or is being drained this cycle.
    always_comb begin
        valid_d   = valid_q;
        high_d    = high_q;
        period_d  = period_q;
        overrun_d = overrun_q;
        if (complete) begin
            if (!valid_q || meas_ready) begin
                valid_d  = 1'b1;
                high_d   = h_acc_q;
                period_d = p_acc_q;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && meas_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            high_q    <= '0;
            period_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            high_q    <= high_d;
            period_q  <= period_d;
            overrun_q <= overrun_d;
        end
    end

    assign meas_valid = valid_q;
    assign high_cnt   = high_q;
    assign period_cnt = period_q;
    assign overrun    = overrun_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: segment-level waveform model with a result scoreboard.
module tb_pwm_capture;

    localparam int unsigned CntW = 16;
    localparam int unsigned MaxP = 20;
`ifdef PWM_CAPTURE_SYNC_EN
    localparam int Lat = 3;
`else
    localparam int Lat = 2;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            pwm_in = 1'b0;
    logic            meas_ready = 1'b1;
    logic            meas_valid;
    logic [CntW-1:0] high_cnt;
    logic [CntW-1:0] period_cnt;
    logic            overrun;
    logic            timeout;

    pwm_capture #(
        .CNT_W      (CntW),
        .MAX_PERIOD (MaxP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .meas_valid (meas_valid),
        .meas_ready (meas_ready),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int h;
        int p;
    } meas_t;

    meas_t exp_q[$];
    bit    scb_on = 1'b0;
    int    bh[$];
    int    bl[$];

    // Every accepted result must match the oldest expected period.
    always @(negedge clk) begin
        meas_t m;
        if (scb_on && meas_valid && meas_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_meas", 1, 0);
            end else begin
                m = exp_q.pop_front();
                check("high_cnt", 64'(high_cnt), 64'(m.h));
                check("period_cnt", 64'(period_cnt), 64'(m.p));
            end
        end
    end

    task automatic seg(input int h, input int l);
        pwm_in = 1'b1;
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    // Each segment completes at the following rise; a closing rise ends the burst.
    task automatic burst();
        for (int i = 0; i < bh.size(); i++) begin
            if (i > 0) exp_q.push_back('{h: bh[i-1], p: bh[i-1] + bl[i-1]});
            seg(bh[i], bl[i]);
        end
        exp_q.push_back('{h: bh[bh.size()-1], p: bh[bh.size()-1] + bl[bl.size()-1]});
        pwm_in = 1'b1;
        @(negedge clk);
        pwm_in = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        int n;
        bit found;
        int pulses;
        int first;
        int run;
        int maxrun;

        repeat (3) @(negedge clk);
        check("rst_valid", 64'(meas_valid), 0);
        check("rst_high", 64'(high_cnt), 0);
        check("rst_period", 64'(period_cnt), 0);
        check("rst_overrun", 64'(overrun), 0);
        check("rst_timeout", 64'(timeout), 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Latency from the completing pwm_in rise to meas_valid.
        seg(3, 7);
        pwm_in = 1'b1;
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (meas_valid) found = 1'b1;
        end
        check("latency", 64'(n), 64'(Lat));
        check("lat_high", 64'(high_cnt), 3);
        check("lat_period", 64'(period_cnt), 10);
        @(negedge clk);
        repeat (2) @(negedge clk);
        pwm_in = 1'b0;
        repeat (30) @(negedge clk);

        scb_on = 1'b1;
        bh = {3, 3, 3, 3};
        bl = {7, 7, 7, 7};
        burst();
        bh = {};
        bl = {};
        for (int d = 1; d <= 9; d++) begin
            bh.push_back(d);
            bl.push_back(10 - d);
        end
        burst();
        bh = {};
        bl = {};
        for (int i = 0; i < 12; i++) begin
            bh.push_back(int'($urandom_range(9, 1)));
            bl.push_back(int'($urandom_range(9, 1)));
        end
        burst();
        scb_on = 1'b0;
        check("burst_scb_left", 64'(exp_q.size()), 0);
        check("burst_overrun", 64'(overrun), 0);

        // Completion coinciding with a handshake loads the new result.
        meas_ready = 1'b0;
        seg(2, 3);
        seg(3, 3);
        check("hold_valid", 64'(meas_valid), 1);
        check("hold_high", 64'(high_cnt), 2);
        check("hold_period", 64'(period_cnt), 5);
        pwm_in = 1'b1;
        repeat (Lat - 1) @(negedge clk);
        meas_ready = 1'b1;
        @(posedge clk);
        #1;
        check("same_valid", 64'(meas_valid), 1);
        check("same_high", 64'(high_cnt), 3);
        check("same_period", 64'(period_cnt), 6);
        check("same_overrun", 64'(overrun), 0);
        @(negedge clk);
        pwm_in = 1'b0;
        repeat (30) @(negedge clk);
        check("same_drained", 64'(meas_valid), 0);

        // Two completions while stalled: first result held, overrun set.
        meas_ready = 1'b0;
        seg(2, 5);
        seg(4, 4);
        seg(3, 3);
        pwm_in = 1'b1;
        repeat (Lat + 1) @(negedge clk);
        check("ovr_valid", 64'(meas_valid), 1);
        check("ovr_high", 64'(high_cnt), 2);
        check("ovr_period", 64'(period_cnt), 7);
        check("ovr_flag", 64'(overrun), 1);
        meas_ready = 1'b1;
        @(negedge clk);
        check("ovr_drained", 64'(meas_valid), 0);
        check("ovr_sticky", 64'(overrun), 1);
        pwm_in = 1'b0;
        repeat (30) @(negedge clk);
        check("ovr_sticky_late", 64'(overrun), 1);

        // Stuck-high input: exactly one single-cycle timeout, no result.
        scb_on = 1'b1;
        pwm_in = 1'b1;
        pulses = 0;
        first = 0;
        run = 0;
        maxrun = 0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (timeout) begin
                pulses++;
                run++;
                if (first == 0) first = i;
            end else begin
                run = 0;
            end
            if (run > maxrun) maxrun = run;
        end
        check("to_pulses", 64'(pulses), 1);
        check("to_width", 64'(maxrun), 1);
        check("to_time", 64'(first), 64'(MaxP + Lat));
        check("to_valid", 64'(meas_valid), 0);
        pwm_in = 1'b0;
        repeat (5) @(negedge clk);
        scb_on = 1'b0;

        // Reset mid-LOW with pwm_in high at release.
        seg(3, 3);
        rst = 1'b0;
        pwm_in = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_valid", 64'(meas_valid), 0);
        check("mid_rst_high", 64'(high_cnt), 0);
        check("mid_rst_period", 64'(period_cnt), 0);
        check("mid_rst_overrun", 64'(overrun), 0);
        check("mid_rst_timeout", 64'(timeout), 0);
        rst = 1'b1;
        scb_on = 1'b1;
        repeat (4) @(negedge clk);
        pwm_in = 1'b0;
        repeat (5) @(negedge clk);
        seg(2, 6);
        exp_q.push_back('{h: 2, p: 8});
        pwm_in = 1'b1;
        repeat (Lat + 2) @(negedge clk);
        pwm_in = 1'b0;
        repeat (30) @(negedge clk);
        scb_on = 1'b0;
        check("rst_scb_left", 64'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
